// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Inserts a signed immediate into a template RISC-V instruction
//                (I/S/B/J formats) and emits it with a sequential word address
//                over a one-deep valid/ready output register.
//                Optional macro IMM_RANGE_CHECK_EN drops out-of-range
//                immediates, raises a sticky err and parks in the ERR state.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_immsrc,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_instr,
    output logic        err,
    output logic [15:0] count
);

    localparam logic [1:0] c_fmt_i = 2'b00;
    localparam logic [1:0] c_fmt_s = 2'b01;
    localparam logic [1:0] c_fmt_b = 2'b10;
    localparam logic [1:0] c_fmt_j = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_addr;
    logic [31:0] r_wr_addr;
    logic [15:0] r_count;
    logic        r_err;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_imm_bad;
    logic        w_take;
    logic        w_drop;
    logic [31:0] w_encoded;

    // Only RUN accepts; a load cycle never accepts, and the output register
    // must be empty or draining this cycle.
    assign w_in_ready = !reset && (r_state == ST_RUN) && !load &&
                        (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_take     = w_accept && !w_imm_bad;
    assign w_drop     = w_accept && w_imm_bad;

`ifdef IMM_RANGE_CHECK_EN
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;
    logic w_unused_addr;

    // Sign-extension tests: upper bits must all equal the field's sign bit.
    assign w_fits12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign w_fits13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign w_fits21 = (in_imm[31:20] == {12{in_imm[20]}});

    // Flag immediates that cannot be represented exactly in the chosen format.
    always_comb begin
        w_imm_bad = 1'b0;
        case (in_immsrc)
            c_fmt_i: w_imm_bad = !w_fits12;
            c_fmt_s: w_imm_bad = !w_fits12;
            c_fmt_b: w_imm_bad = !w_fits13 || in_imm[0];
            c_fmt_j: w_imm_bad = !w_fits21 || in_imm[0];
            default: w_imm_bad = 1'b0;
        endcase
    end

    // Low address bits are forced to zero, so they are intentionally ignored.
    assign w_unused_addr = &{1'b0, load_addr[1:0]};
`else
    logic w_unused_bits;

    // No range check: excess immediate bits are silently discarded.
    assign w_imm_bad     = 1'b0;
    assign w_unused_bits = &{1'b0, load_addr[1:0], in_imm[31:21]};
`endif

    // Scatter the immediate into the format's fields; everything else is
    // copied from the template instruction.
    always_comb begin
        w_encoded = in_instr;
        case (in_immsrc)
            c_fmt_i: w_encoded = {in_imm[11:0], in_instr[19:0]};
            c_fmt_s: w_encoded = {in_imm[11:5], in_instr[24:12],
                                  in_imm[4:0], in_instr[6:0]};
            c_fmt_b: w_encoded = {in_imm[12], in_imm[10:5], in_instr[24:12],
                                  in_imm[4:1], in_imm[11], in_instr[6:0]};
            c_fmt_j: w_encoded = {in_imm[20], in_imm[10:1], in_imm[11],
                                  in_imm[19:12], in_instr[11:0]};
            default: w_encoded = in_instr;
        endcase
    end

    // Next-state logic: load always (re)enters RUN; a dropped request parks in ERR.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (load)        w_state_nxt = ST_RUN;
                else if (w_drop) w_state_nxt = ST_ERR;
            end
            ST_ERR: begin
                if (load) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Output register: capture on accept (even while draining), clear on drain,
    // otherwise hold the pending word untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_addr  <= 32'd0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_encoded;
            r_out_addr  <= r_wr_addr;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Write-address and accepted-word counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_addr <= 32'd0;
            r_count   <= 16'd0;
        end else begin
            if (load)        r_wr_addr <= {load_addr[31:2], 2'b00};
            else if (w_take) r_wr_addr <= r_wr_addr + 32'd4;
            if (w_take)      r_count   <= r_count + 16'd1;
        end
    end

    // Sticky range error, cleared by reset or load.
    always_ff @(posedge clk) begin
        if (reset)       r_err <= 1'b0;
        else if (load)   r_err <= 1'b0;
        else if (w_drop) r_err <= 1'b1;
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err       = r_err;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Directed self-checking bench for imm_encoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        load;
    logic [31:0] load_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_immsrc;
    logic [31:0] in_imm;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_instr;
    logic        err;
    logic [15:0] count;

    int n_tests;
    int n_fail;

    imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_addr (load_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_immsrc (in_immsrc),
        .in_imm    (in_imm),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_instr (out_instr),
        .err       (err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] addr);
        load      = 1'b1;
        load_addr = addr;
        tick();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        n_tests++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
        n_tests++; if (out_addr !== 32'd0)  begin n_fail++; $display("FAIL rst_out_addr got %h want 0", out_addr); end
        n_tests++; if (count !== 16'd0)     begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_tests++; if (err !== 1'b0)        begin n_fail++; $display("FAIL rst_err got %0b want 0", err); end
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_immsrc = 2'b00;
        in_imm    = 32'd1;
        in_instr  = 32'h13;
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready got %0b want 0", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_output got %0b want 0", out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_i_type();
        do_load(32'h0000_0103);
        in_valid  = 1'b1;
        in_immsrc = 2'b00;
        in_imm    = 32'hFFFF_FFFF;
        in_instr  = 32'h0000_0013;
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL i_in_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1)         begin n_fail++; $display("FAIL i_out_valid got %0b want 1", out_valid); end
        n_tests++; if (out_instr !== 32'hFFF00013) begin n_fail++; $display("FAIL i_out_instr got %h want fff00013", out_instr); end
        n_tests++; if (out_addr !== 32'h100)       begin n_fail++; $display("FAIL i_out_addr got %h want 00000100", out_addr); end
        n_tests++; if (count !== 16'd1)            begin n_fail++; $display("FAIL i_count got %0d want 1", count); end
    endtask

    task automatic test_s_b();
        in_valid  = 1'b1;
        in_immsrc = 2'b01;
        in_imm    = 32'd8;
        in_instr  = 32'h0000_2023;
        tick();
        n_tests++; if (out_instr !== 32'h00002423) begin n_fail++; $display("FAIL s_out_instr got %h want 00002423", out_instr); end
        n_tests++; if (out_addr !== 32'h104)       begin n_fail++; $display("FAIL s_out_addr got %h want 00000104", out_addr); end
        in_immsrc = 2'b10;
        in_imm    = 32'hFFFF_FFFC;
        in_instr  = 32'h0000_0063;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_instr !== 32'hFE000EE3) begin n_fail++; $display("FAIL b_out_instr got %h want fe000ee3", out_instr); end
        n_tests++; if (out_addr !== 32'h108)       begin n_fail++; $display("FAIL b_out_addr got %h want 00000108", out_addr); end
        n_tests++; if (count !== 16'd3)            begin n_fail++; $display("FAIL b_count got %0d want 3", count); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_j_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_immsrc = 2'b11;
        in_imm    = 32'd8;
        in_instr  = 32'h0000_006F;
        tick();
        // A different request waits while the output is stalled.
        in_immsrc = 2'b00;
        in_imm    = 32'd4;
        in_instr  = 32'h0000_0013;
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL j_stall_in_ready[%0d] got %0b want 0", k, in_ready); end
            n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h0080006F || out_addr !== 32'h10C)
                begin n_fail++; $display("FAIL j_hold[%0d] got v=%0b %h @%h want v=1 0080006f @0000010c", k, out_valid, out_instr, out_addr); end
            tick();
        end
        n_tests++; if (count !== 16'd4) begin n_fail++; $display("FAIL j_count got %0d want 4", count); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL j_transfer got %0b want 0", out_valid); end
        n_tests++; if (count !== 16'd4)    begin n_fail++; $display("FAIL j_count_after got %0d want 4", count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_instr;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'b1;
            in_immsrc = 2'b00;
            in_imm    = k + 1;
            in_instr  = 32'h0000_0093;
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %0b want 1", k, in_ready); end
            tick();
            exp_instr = ((k + 1) << 20) | 32'h93;
            n_tests++; if (out_valid !== 1'b1 || out_instr !== exp_instr || out_addr !== 32'h110 + 4 * k)
                begin n_fail++; $display("FAIL b2b_word[%0d] got v=%0b %h @%h want v=1 %h @%h", k, out_valid, out_instr, out_addr, exp_instr, 32'h110 + 4 * k); end
        end
        in_valid = 1'b0;
        n_tests++; if (count !== 16'd8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", count); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_load_pending();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_immsrc = 2'b01;
        in_imm    = 32'd0;
        in_instr  = 32'h0000_2023;
        tick();
        load      = 1'b1;
        load_addr = 32'h200;
        in_imm    = 32'd3;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ldp_in_ready got %0b want 0", in_ready); end
        tick();
        load = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h2023 || out_addr !== 32'h120)
            begin n_fail++; $display("FAIL ldp_hold got v=%0b %h @%h want v=1 00002023 @00000120", out_valid, out_instr, out_addr); end
        // Simultaneous drain and accept.
        out_ready = 1'b1;
        in_immsrc = 2'b00;
        in_imm    = 32'd5;
        in_instr  = 32'h0000_0013;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ldp_drain_accept got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h00500013 || out_addr !== 32'h200)
            begin n_fail++; $display("FAIL ldp_new_word got v=%0b %h @%h want v=1 00500013 @00000200", out_valid, out_instr, out_addr); end
        n_tests++; if (count !== 16'd10) begin n_fail++; $display("FAIL ldp_count got %0d want 10", count); end
        tick();
    endtask

    task automatic test_wrap();
        do_load(32'hFFFF_FFFE);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_immsrc = 2'b00;
        in_imm    = 32'd0;
        in_instr  = 32'h0000_0013;
        tick();
        n_tests++; if (out_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffffc", out_addr); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1 got %h want 00000000", out_addr); end
        n_tests++; if (count !== 16'd12)   begin n_fail++; $display("FAIL wrap_count got %0d want 12", count); end
        tick();
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_immsrc = 2'b00;
        in_imm    = 32'd2048;
        in_instr  = 32'h0000_0013;
        tick();
`ifdef IMM_RANGE_CHECK_EN
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rng_dropped got %0b want 0", out_valid); end
        n_tests++; if (err !== 1'b1)       begin n_fail++; $display("FAIL rng_err got %0b want 1", err); end
        n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rng_in_ready got %0b want 0", in_ready); end
        n_tests++; if (count !== 16'd12)   begin n_fail++; $display("FAIL rng_count got %0d want 12", count); end
        in_valid = 1'b0;
        do_load(32'h300);
        n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL rng_err_clear got %0b want 0", err); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rng_rerun got %0b want 1", in_ready); end
`else
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h80000013)
            begin n_fail++; $display("FAIL rng_nocheck got v=%0b %h want v=1 80000013", out_valid, out_instr); end
        n_tests++; if (err !== 1'b0)     begin n_fail++; $display("FAIL rng_err got %0b want 0", err); end
        n_tests++; if (count !== 16'd13) begin n_fail++; $display("FAIL rng_count got %0d want 13", count); end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_immsrc = 2'b00;
        in_imm    = 32'd7;
        in_instr  = 32'h0000_0013;
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending got %0b want 1", out_valid); end
        reset     = 1'b1;
        load      = 1'b1;
        load_addr = 32'h400;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %0b want 0", out_valid); end
        n_tests++; if (count !== 16'd0)    begin n_fail++; $display("FAIL rmid_count got %0d want 0", count); end
        n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rmid_in_ready got %0b want 0", in_ready); end
        n_tests++; if (out_addr !== 32'd0) begin n_fail++; $display("FAIL rmid_out_addr got %h want 0", out_addr); end
        reset     = 1'b0;
        load      = 1'b0;
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got %0b want 0", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_output got %0b want 0", out_valid); end
        in_valid = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        load      = 1'b0;
        load_addr = 32'd0;
        in_valid  = 1'b0;
        in_immsrc = 2'b00;
        in_imm    = 32'd0;
        in_instr  = 32'd0;
        out_ready = 1'b0;
        test_reset();
        test_i_type();
        test_s_b();
        test_j_stall();
        test_back_to_back();
        test_load_pending();
        test_wrap();
        test_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
